// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration count and a small magnitude helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] md_abs(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath: 64-bit shift-add multiply or restoring
// shift-subtract divide on unsigned magnitudes, plus the step counter.
// Multiply: acc ends as the 64-bit product.
// Divide:   acc ends as {remainder, quotient}.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] acc,
    output logic        last
);

    logic [63:0]         acc_q, acc_d;
    logic [31:0]         b_q, b_d;
    logic                div_q, div_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_diff;

    // Next-state for the accumulator: load on start, one radix-2 step per enable.
    always_comb begin
        acc_d     = acc_q;
        b_d       = b_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        // Multiply: conditionally add multiplicand into the high half, then shift right.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        // Divide: shift partial remainder left by one and trial-subtract.
        // A difference that fits means it is below the divisor, so 32 bits suffice.
        rem_shift = acc_q[63:31];
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_diff  = rem_shift[31:0] - b_q;
        if (start) begin
            acc_d = {32'd0, op_a};
            b_d   = op_b;
            div_d = is_div;
            cnt_d = '0;
        end else if (step) begin
            if (div_q) begin
                acc_d = rem_ge ? {rem_diff, acc_q[30:0], 1'b1}
                               : {rem_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
                acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == MD_CNT_W'(MD_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional build macro MULDIV_FAST_MUL_EN: MUL/MULTU use a combinational
// multiplier and complete in one cycle (IDLE -> DONE); divides stay iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] HILO_RST_VAL = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_e   state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        neg_res_q, neg_res_d;   // operand signs differ
    logic        neg_rem_q, neg_rem_d;   // dividend negative
    logic        divz_q, divz_d;         // divisor was zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result_q, result_d;

    logic        it_start, it_step, it_is_div, it_last;
    logic [31:0] it_a, it_b;
    logic [63:0] it_acc;

    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    // Unsigned 64-bit product; its low word also equals the low word of the signed product.
    assign fast_prod = {32'd0, rs_val} * {32'd0, rt_val};
`endif

    muldiv_iter u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (it_start),
        .step   (it_step),
        .is_div (it_is_div),
        .op_a   (it_a),
        .op_b   (it_b),
        .acc    (it_acc),
        .last   (it_last)
    );

    // Sign correction of the raw unsigned datapath result.
    always_comb begin
        prod_fix = neg_res_q ? (~it_acc + 64'd1) : it_acc;
        quot_fix = divz_q ? 32'hFFFF_FFFF
                          : (neg_res_q ? (~it_acc[31:0] + 32'd1) : it_acc[31:0]);
        rem_fix  = neg_rem_q ? (~it_acc[63:32] + 32'd1) : it_acc[63:32];
    end

    // FSM next-state, operand capture and HI/LO/result updates.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        it_start  = 1'b0;
        it_step   = 1'b0;
        it_is_div = 1'b0;
        it_a      = rs_val;
        it_b      = rt_val;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    case (op)
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
`ifdef MULDIV_FAST_MUL_EN
                        MD_MUL: begin
                            result_d = fast_prod[31:0];
                            op_d     = op;
                            state_d  = ST_DONE;
                        end
                        MD_MULTU: begin
                            hi_d    = fast_prod[63:32];
                            lo_d    = fast_prod[31:0];
                            op_d    = op;
                            state_d = ST_DONE;
                        end
`else
                        MD_MUL, MD_MULTU,
`endif
                        MD_DIV, MD_DIVU: begin
                            // Signed ops work on magnitudes and fix the sign in FIX.
                            if (op == MD_MUL || op == MD_DIV) begin
                                it_a      = md_abs(rs_val);
                                it_b      = md_abs(rt_val);
                                neg_res_d = rs_val[31] ^ rt_val[31];
                                neg_rem_d = rs_val[31];
                            end else begin
                                neg_res_d = 1'b0;
                                neg_rem_d = 1'b0;
                            end
                            it_start  = 1'b1;
                            it_is_div = (op == MD_DIV) || (op == MD_DIVU);
                            divz_d    = (rt_val == 32'd0);
                            op_d      = op;
                            state_d   = ST_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                case (op_q)
                    MD_MUL:   result_d = prod_fix[31:0];
                    MD_MULTU: begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                    default: begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= HILO_RST_VAL;
            lo_q      <= HILO_RST_VAL;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized
// ops compared against an arithmetic reference model of HI/LO/result.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy, done;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m, res_m;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 0;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int DIV_BUSY = 33;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .HILO_RST_VAL(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    // Reference model: architectural effect of one accepted op.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                q = sa * sb;
                res_m = 32'(q);
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo_m = 32'(q);
                    hi_m = 32'(r);
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = a;
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue an arithmetic op from IDLE, wait (bounded) for done, return to IDLE.
    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output int bcnt, output logic busy_at_done);
        req = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; bcnt = 0; busy_at_done = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout op=%0d got done=%b want 1", o, done);
        end else begin
            busy_at_done = busy;
            @(posedge clk); #1;
        end
        model_apply(o, a, b);
    endtask

    // Issue a single-edge op (MTHI/MTLO/ignored codes).
    task automatic run_idle(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        req = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        req = 1'b0;
        model_apply(o, a, b);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0; res_m = 32'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        $display("reset: busy=%b done=%b result=%h hi=%h lo=%h", busy, done, result, hi, lo);
    endtask

    task automatic test_multu();
        int lat, bc;
        logic bd;
        run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, bd);
        $display("MULTU ffffffff*ffffffff: hi=%h lo=%h lat=%0d busy=%0d", hi, lo, lat, bc);
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
        checks++; if (bc != MUL_BUSY) begin errors++; $display("FAIL multu_busy_cycles got %0d want %0d", bc, MUL_BUSY); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL busy_with_done got %b want 0", bd); end
    endtask

    task automatic test_div();
        int lat, bc;
        logic bd;
        run_arith(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bc, bd);
        $display("DIV -7/2: hi=%h lo=%h lat=%0d", hi, lo, lat);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        checks++; if (lat != DIV_LAT || bc != DIV_BUSY) begin errors++; $display("FAIL div_timing got lat=%0d busy=%0d want %0d/%0d", lat, bc, DIV_LAT, DIV_BUSY); end
        run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, bd);
        $display("DIV 80000000/-1: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", hi); end
        run_arith(3'd3, 32'd5, 32'd0, lat, bc, bd);
        $display("DIVU 5/0: hi=%h lo=%h lat=%0d", hi, lo, lat);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divz_hi got %h want 5", hi); end
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL divz_latency got %0d want %0d", lat, DIV_LAT); end
    endtask

    task automatic test_mul_preload();
        int lat, bc;
        logic bd;
        run_idle(3'd4, 32'h11, 32'd0);
        run_idle(3'd5, 32'h22, 32'd0);
        run_arith(3'd0, 32'hFFFF_FFFE, 32'd3, lat, bc, bd);
        $display("MUL -2*3: result=%h hi=%h lo=%h", result, hi, lo);
        checks++; if (result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_result got %h want fffffffa", result); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mul_hi_kept got %h want 11", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mul_lo_kept got %h want 22", lo); end
    endtask

    task automatic test_mthi();
        run_idle(3'd4, 32'h1234, 32'd0);
        $display("MTHI 1234: hi=%h busy=%b done=%b", hi, busy, done);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h want 1234", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_ignore_busy();
        int n;
        req = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        req = 1'b1; op = 3'd5; rs_val = 32'd5;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_timeout got done=%b want 1", done); end
        @(posedge clk); #1;
        model_apply(3'd2, 32'd100, 32'd7);
        $display("DIV 100/7 with MTLO mid-op: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ignore_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL ignore_hi got %h want 2", hi); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic bd, saw_done;
        req = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0; res_m = 32'd0;
        $display("abort DIVU: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", saw_done); end
        run_arith(3'd1, 32'd3, 32'd4, lat, bc, bd);
        $display("MULTU 3*4 after abort: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL post_abort_multu got %h/%h want 0/c", hi, lo); end
    endtask

    task automatic test_random();
        int lat, bc;
        logic bd;
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 17));
                default: ;
            endcase
            if (o <= 3'd3) begin
                run_arith(o, a, b, lat, bc, bd);
                checks++;
                if (lat != ((o <= 3'd1) ? MUL_LAT : DIV_LAT)) begin
                    errors++;
                    $display("FAIL rand_latency op=%0d got %0d want %0d", o, lat, (o <= 3'd1) ? MUL_LAT : DIV_LAT);
                end
            end else begin
                run_idle(o, a, b);
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle_flags op=%0d got busy=%b done=%b want 0/0", o, busy, done);
                end
            end
            $display("rand %0d: op=%0d rs=%h rt=%h -> hi=%h lo=%h result=%h", i, o, a, b, hi, lo, result);
            checks++;
            if (hi !== hi_m || lo !== lo_m || result !== res_m) begin
                errors++;
                $display("FAIL rand_regs op=%0d rs=%h rt=%h got hi=%h lo=%h res=%h want hi=%h lo=%h res=%h",
                         o, a, b, hi, lo, result, hi_m, lo_m, res_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_div();
        test_mul_preload();
        test_mthi();
        test_ignore_busy();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with the architectural HI/LO registers for the 54-instruction single-cycle CPU. It sits directly downstream of the instruction decoder. The CPU control derives the `op` code from the decoder's MUL/MULTU/DIV/DIVU/MTHI/MTLO flags and supplies the Rs/Rt register values. The unit iterates over 32 cycles and holds `busy` so control stalls PC and register-file write-back. MFHI/MFLO read the `hi`/`lo` outputs directly.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- HILO_RST_VAL, 32'h0, value loaded into HI and LO on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  operation request; sampled only when busy=0
- op  in  3  operation code: 0 MUL, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored
- rs_val  in  32  Rs register value (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  32  Rt register value (divisor / multiplier)
- busy  out  1  operation in progress; control stalls while high
- done  out  1  one-cycle pulse when a MUL/MULTU/DIV/DIVU result is committed
- result  out  32  low word of the last MUL; written to Rd in the done cycle
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: busy=0, done=0, result=0, hi=lo=HILO_RST_VAL, state=IDLE, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE
  - req with op 4 or 5: write rs_val into hi or lo at that edge; stay IDLE; no busy, no done.
  - req with op 0–3: latch operands as magnitudes (absolute values for MUL/DIV), latch the sign info and op; go to CALC with cnt=0.
  - req with op 6–7: no effect.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - cnt increments each cycle; after the 32nd step go to FIX.
- FIX: apply sign correction.
  - MUL/DIV product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Next state is DONE.
- DONE
  - done=1 for exactly this cycle.
  - hi/lo, or `result` for MUL, were updated at the edge entering DONE.
  - Next state is IDLE.
- busy=1 exactly while state is CALC or FIX; busy and done are never both 1.
- Latency: req sampled at edge N; done high in the cycle after edge N+33; busy high in cycles N+1..N+33.
- req while busy or done is ignored. Control must hold the instruction stalled; the unit never queues.
- MUL writes `result` only (low 32 bits of the signed product); HI/LO are unchanged.
- MULTU/DIV/DIVU write HI/LO only; `result` keeps its old value.
- Multiply results: MULTU gives HI=product[63:32], LO=product[31:0].
- Divide results: DIV/DIVU give LO=quotient, HI=remainder; quotient truncates toward zero.
- Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=rs_val. The unit takes the full 34-cycle latency regardless.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0 (wraps, no trap).
- rst asserted in any state aborts the operation at that edge: outputs take reset values and no done is produced.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL/MULTU use a combinational 32x32 multiplier. The FSM goes IDLE -> DONE directly, so done is high in the cycle after the req edge with busy never asserted. Divides are unchanged.
- Undefined: all four arithmetic ops use the 34-cycle iterative path.

Decomposition:
- Package muldiv_pkg holds:
  - the op codes (MD_MUL, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state encoding;
  - the iteration count constant MD_ITERS=32.
- One natural sub-module, muldiv_iter: the 64-bit shift-add/shift-subtract datapath with its counter. The parent owns the FSM, sign handling, and HI/LO/result registers.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the req edge; busy high for 33 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5.
- MUL rs=0xFFFFFFFE, rt=3 with hi=0x11, lo=0x22 preloaded -> result=0xFFFFFFFA; hi/lo remain 0x11/0x22.
- MTHI 0x1234 while idle -> hi=0x1234 after one edge. A req (MTLO 0x5) issued mid-DIV -> ignored, lo ends as the quotient.
- rst pulsed 10 cycles into a DIVU -> next cycle busy=0, hi=lo=0; done never asserts. A new MULTU 3*4 afterwards -> lo=12, hi=0.
